// File: rtl/cpu_core_params.sv
// Shared types for the SRAM bus arbiter: request bundle, FSM state, owner.
package cpu_core_params;

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } SramRequest;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    WAIT
  } ArbState;

  typedef enum logic {
    OWNER_I,
    OWNER_D
  } ArbOwner;

endpackage

// File: rtl/sram_arb_picker.sv
// Priority policy for the arbiter: D first, I forced through once starved.
module sram_arb_picker
  import cpu_core_params::*;
(
  input  logic    i_req,
  input  logic    d_req,
  input  logic    starve_hit,
  output ArbOwner winner
);

  logic force_i;
  logic take_d;

  assign force_i = i_req & starve_hit;
  assign take_d  = d_req & ~force_i;

  always_comb begin
    winner = OWNER_I;
    unique case (1'b1)
      take_d:  winner = OWNER_D;
      default: winner = OWNER_I;
    endcase
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between fetch (I) and memory (D) requesters,
// one outstanding transaction at a time.
module sram_bus_arbiter
  import cpu_core_params::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  localparam int CLOG = $clog2(STARVE_LIMIT + 1);
  localparam int CW   = (CLOG < 2) ? 2 : CLOG;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  ArbState       state_q, state_d;
  ArbOwner       owner_q, owner_d;
  ArbOwner       pick, cur;
  logic [CW-1:0] starve_q, starve_d;
  SramRequest    i_bus, d_bus, m_bus;
  logic          starve_hit;
  logic          addr_acc;
  logic          data_acc;

  assign i_bus = '{req: i_req, wr: i_wr, size: i_size,
                   addr: i_addr, wdata: i_wdata};
  assign d_bus = '{req: d_req, wr: d_wr, size: d_size,
                   addr: d_addr, wdata: d_wdata};

  assign starve_hit = (starve_q == LIMIT);

  sram_arb_picker u_picker (
    .i_req      (i_req),
    .d_req      (d_req),
    .starve_hit (starve_hit),
    .winner     (pick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= OWNER_I;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    cur      = (state_q == IDLE) ? pick : owner_q;
    m_bus    = (cur == OWNER_D) ? d_bus : i_bus;
    unique case (state_q)
      IDLE:    m_bus.req = i_req | d_req;
      HOLD:    m_bus.req = 1'b1;
      default: m_bus.req = 1'b0;
    endcase
    addr_acc = m_bus.req & m_addr_ok;
    data_acc = (state_q == WAIT) & m_data_ok;

    unique case (state_q)
      IDLE: if (m_bus.req) begin
        owner_d = cur;
        state_d = addr_acc ? WAIT : HOLD;
      end
      HOLD: if (addr_acc) state_d = WAIT;
      WAIT: if (data_acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // I acceptance wins over the idle clear; D only counts while I waits
    if (addr_acc && cur == OWNER_I)
      starve_d = '0;
    else if (addr_acc && i_req)
      starve_d = starve_hit ? starve_q : starve_q + 1'b1;
    else if (state_q == IDLE && !i_req)
      starve_d = '0;
  end

  assign m_req     = m_bus.req;
  assign m_wr      = m_bus.wr;
  assign m_size    = m_bus.size;
  assign m_addr    = m_bus.addr;
  assign m_wdata   = m_bus.wdata;

  assign i_addr_ok = addr_acc & (cur == OWNER_I);
  assign d_addr_ok = addr_acc & (cur == OWNER_D);
  assign i_data_ok = data_acc & (owner_q == OWNER_I);
  assign d_data_ok = data_acc & (owner_q == OWNER_D);
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic vs a model.
module tb_sram_bus_arbiter;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  sram_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size),
    .i_addr(i_addr), .i_wdata(i_wdata),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 0; i_wr = 0; i_size = 2; i_addr = 0; i_wdata = 0;
    d_req = 0; d_wr = 0; d_size = 2; d_addr = 0; d_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; m_addr_ok = 1; m_data_ok = 1;
    step(); step(); settle();
    checks++;
    if ({m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok});
    end
    reset = 0; m_addr_ok = 0; m_data_ok = 0;
    step();
  endtask

  task automatic test_d_only();
    d_req = 1; d_addr = 32'h100; d_size = 2; m_addr_ok = 1; settle();
    checks++;
    if ({m_req, d_addr_ok, i_addr_ok, m_addr} !== {3'b110, 32'h100}) begin
      errors++;
      $display("FAIL d_only_addr: got %b/%b/%b/%h expected 1/1/0/00000100",
               m_req, d_addr_ok, i_addr_ok, m_addr);
    end
    step(); d_req = 0; m_addr_ok = 0; settle();
    checks++;
    if (d_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL d_only_early: got d_data_ok=%b expected 0", d_data_ok);
    end
    step(); m_data_ok = 1; m_rdata = 32'hDEADBEEF; settle();
    checks++;
    if ({d_data_ok, i_data_ok, d_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL d_only_data: got %b/%b/%h expected 1/0/deadbeef",
               d_data_ok, i_data_ok, d_rdata);
    end
    step(); m_data_ok = 0;
  endtask

  task automatic test_both();
    i_req = 1; i_addr = 32'h40; d_req = 1; d_addr = 32'h300;
    m_addr_ok = 1; settle();
    checks++;
    if ({d_addr_ok, i_addr_ok} !== 2'b10) begin
      errors++;
      $display("FAIL both_d_first: got d=%b i=%b expected d=1 i=0",
               d_addr_ok, i_addr_ok);
    end
    step(); d_req = 0; m_data_ok = 1; m_rdata = 32'h1111; settle();
    checks++;
    if ({d_data_ok, i_addr_ok, m_req} !== 3'b100) begin
      errors++;
      $display("FAIL both_d_data: got %b expected 100",
               {d_data_ok, i_addr_ok, m_req});
    end
    step(); m_data_ok = 0; settle();
    checks++;
    if ({i_addr_ok, m_addr} !== {1'b1, 32'h40}) begin
      errors++;
      $display("FAIL both_i_next: got %b/%h expected 1/00000040",
               i_addr_ok, m_addr);
    end
    step(); i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h2222;
    settle();
    checks++;
    if ({i_data_ok, d_data_ok, i_rdata} !== {2'b10, 32'h2222}) begin
      errors++;
      $display("FAIL both_i_data: got %b/%b/%h expected 1/0/00002222",
               i_data_ok, d_data_ok, i_rdata);
    end
    step(); m_data_ok = 0;
  endtask

  task automatic test_hold();
    i_req = 1; i_addr = 32'h400;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin d_req = 1; d_addr = 32'h800; end
      settle();
      checks++;
      if ({m_req, i_addr_ok, d_addr_ok, m_addr} !== {3'b100, 32'h400}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got %b/%b/%b/%h expected 1/0/0/00000400",
                 c, m_req, i_addr_ok, d_addr_ok, m_addr);
      end
      step();
    end
    m_addr_ok = 1; settle();
    checks++;
    if ({i_addr_ok, d_addr_ok} !== 2'b10) begin
      errors++;
      $display("FAIL hold_accept: got i=%b d=%b expected i=1 d=0",
               i_addr_ok, d_addr_ok);
    end
    step(); i_req = 0; m_addr_ok = 0; m_data_ok = 1; settle();
    checks++;
    if ({i_data_ok, d_data_ok} !== 2'b10) begin
      errors++;
      $display("FAIL hold_i_data: got i=%b d=%b expected i=1 d=0",
               i_data_ok, d_data_ok);
    end
    step(); m_data_ok = 0; m_addr_ok = 1; settle();
    checks++;
    if ({d_addr_ok, m_addr} !== {1'b1, 32'h800}) begin
      errors++;
      $display("FAIL hold_d_after: got %b/%h expected 1/00000800",
               d_addr_ok, m_addr);
    end
    step(); d_req = 0; m_addr_ok = 0; m_data_ok = 1; settle();
    checks++;
    if (d_data_ok !== 1'b1) begin
      errors++;
      $display("FAIL hold_d_data: got %b expected 1", d_data_ok);
    end
    step(); m_data_ok = 0;
  endtask

  task automatic test_starve();
    string exp_order = "DDDDID";
    byte   got;
    i_req = 1; i_addr = 32'h1000; d_req = 1; d_addr = 32'h2000;
    for (int t = 0; t < 6; t++) begin
      m_addr_ok = 1; m_data_ok = 0; settle();
      got = (d_addr_ok && !i_addr_ok) ? "D" :
            (i_addr_ok && !d_addr_ok) ? "I" : "?";
      checks++;
      if (got !== exp_order[t]) begin
        errors++;
        $display("FAIL starve_grant%0d: got %c expected %c",
                 t, got, exp_order[t]);
      end
      step(); m_addr_ok = 0; m_data_ok = 1;
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_spurious_reset();
    m_data_ok = 1; settle();
    checks++;
    if ({i_data_ok, d_data_ok} !== 2'b00) begin
      errors++;
      $display("FAIL spurious_data: got %b expected 00", {i_data_ok, d_data_ok});
    end
    step(); m_data_ok = 0;
    d_req = 1; d_addr = 32'h55; m_addr_ok = 1;
    step(); d_req = 0; m_addr_ok = 0; reset = 1;
    step(); reset = 0; m_data_ok = 1; settle();
    checks++;
    if ({m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !== 5'b0) begin
      errors++;
      $display("FAIL reset_in_wait: got %b expected 00000",
               {m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok});
    end
    step(); m_data_ok = 0; d_req = 1; m_addr_ok = 1; settle();
    checks++;
    if (d_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL reset_then_idle: got %b expected 1", d_addr_ok);
    end
    step(); d_req = 0; m_addr_ok = 0; m_data_ok = 1;
    step(); m_data_ok = 0;
  endtask

  task automatic test_write();
    d_req = 1; d_wr = 1; d_size = 1; d_addr = 32'h202; d_wdata = 32'h0000BEEF;
    settle();
    checks++;
    if ({m_req, m_wr, m_size, m_addr, m_wdata} !==
        {1'b1, 1'b1, 2'd1, 32'h202, 32'h0000BEEF}) begin
      errors++;
      $display("FAIL write_fwd: got %b/%b/%0d/%h/%h expected 1/1/1/00000202/0000beef",
               m_req, m_wr, m_size, m_addr, m_wdata);
    end
    step(); m_addr_ok = 1; settle();
    checks++;
    if (d_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL write_accept: got %b expected 1", d_addr_ok);
    end
    step(); d_req = 0; d_wr = 0; m_addr_ok = 0; settle();
    checks++;
    if (d_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL write_early: got %b expected 0", d_data_ok);
    end
    step(); m_data_ok = 1; settle();
    checks++;
    if (d_data_ok !== 1'b1) begin
      errors++;
      $display("FAIL write_data: got %b expected 1", d_data_ok);
    end
    step(); m_data_ok = 0;
  endtask

  // Transaction-level model: who owns the bus, whether its address went out,
  // and how many D grants I has sat through.
  task automatic test_random();
    int busy = 0;
    bit adone = 0;
    int sv = 0;
    int win, own;
    bit e_mreq, acc, dat, drop_i, drop_d;
    logic [31:0] e_addr;
    idle_inputs();
    reset = 1; step(); reset = 0;
    for (int n = 0; n < 400; n++) begin
      if (!i_req && $urandom_range(2) == 0) begin
        i_req = 1; i_addr = $urandom; i_wdata = $urandom;
        i_wr = 1'($urandom_range(1)); i_size = 2'($urandom_range(2));
      end
      if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1; d_addr = $urandom; d_wdata = $urandom;
        d_wr = 1'($urandom_range(1)); d_size = 2'($urandom_range(2));
      end
      m_addr_ok = 1'($urandom_range(1));
      m_data_ok = ($urandom_range(4) < 2);
      m_rdata = $urandom;
      win = 0;
      if (busy == 0) begin
        if (d_req && !(i_req && sv == LIMIT)) win = 2;
        else if (i_req) win = 1;
      end
      own    = (busy != 0) ? busy : win;
      e_mreq = (own != 0) && !adone;
      acc    = e_mreq && m_addr_ok;
      dat    = (busy != 0) && adone && m_data_ok;
      e_addr = (own == 2) ? d_addr : i_addr;
      settle();
      checks++;
      if ({m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !==
          {e_mreq, acc && own == 1, acc && own == 2,
           dat && busy == 1, dat && busy == 2}) begin
        errors++;
        $display("FAIL rand_ctl cyc%0d: got %b expected %b", n,
                 {m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok},
                 {e_mreq, acc && own == 1, acc && own == 2,
                  dat && busy == 1, dat && busy == 2});
      end
      if (e_mreq) begin
        checks++;
        if (m_addr !== e_addr) begin
          errors++;
          $display("FAIL rand_addr cyc%0d: got %h expected %h", n, m_addr, e_addr);
        end
      end
      if (dat) begin
        checks++;
        if (((busy == 1) ? i_rdata : d_rdata) !== m_rdata) begin
          errors++;
          $display("FAIL rand_rdata cyc%0d: got %h expected %h", n,
                   (busy == 1) ? i_rdata : d_rdata, m_rdata);
        end
      end
      if (acc && own == 1) sv = 0;
      else if (acc && own == 2 && i_req) sv = (sv < LIMIT) ? sv + 1 : sv;
      else if (busy == 0 && !i_req) sv = 0;
      drop_i = acc && own == 1;
      drop_d = acc && own == 2;
      if (dat) begin busy = 0; adone = 0; end
      else if (acc) begin busy = own; adone = 1; end
      else if (e_mreq) busy = own;
      step();
      if (drop_i) i_req = 0;
      if (drop_d) d_req = 0;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_d_only();
    test_both();
    test_hold();
    test_starve();
    test_spurious_reset();
    test_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
